pll_clk_out_divider: RTL

//  Synthesizable multi-channel post-divider stage for the PLL output clock tree.

---
 rtl/pll_div_pkg.sv | 29 ++
 rtl/pll_div_channel.sv | 85 ++++++++
 rtl/pll_clk_out_divider.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pll_div_pkg.sv
// Shared types and constant helpers for the PLL output post-divider.
package pll_div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StQualify,
        StSync,
        StRun,
        StDrain
    } pll_state_e;

    function automatic bit params_ok(input int unsigned num_out, input int unsigned div_width,
                                     input int unsigned default_div,
                                     input int unsigned lock_delay);
        return (num_out >= 1) && (num_out <= 16) && (div_width >= 2) && (div_width <= 31) &&
               (default_div >= 2) && (default_div < (32'd1 << div_width)) &&
               (lock_delay >= 1);
    endfunction

    function automatic bit cfg_legal(input int unsigned div, input int unsigned phase);
        return (div >= 2) && (phase < div);
    endfunction

    // Odd ratios get the extra cycle in the high half.
    function automatic int unsigned high_len(input int unsigned div);
        return (div + 1) / 2;
    endfunction

endpackage

// File: rtl/pll_div_channel.sv
// One post-divider channel: wrap counter, live and staged ratio/phase, glitch-free drain.
module pll_div_channel
    import pll_div_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = 7,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_load,
    input  logic                 run,
    input  logic                 drain,
    input  logic                 idle,
    input  logic                 cfg_we_direct,
    input  logic                 cfg_we_stage,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [DIV_WIDTH-1:0] cfg_phase,
    output logic                 clk_out,
    output logic                 frozen,
    output logic                 pending,
    output logic                 applied
);

    logic [DIV_WIDTH-1:0] cnt_q, div_q, phase_q, pend_div_q, pend_phase_q;
    logic                 pend_q, frozen_q, clk_out_q;
    logic                 wrap, hi, counting, apply_now;

    always_comb begin
        wrap      = (cnt_q == div_q - DIV_WIDTH'(1));
        hi        = 32'(cnt_q) < high_len(32'(div_q));
        counting  = run | (drain & ~frozen_q);
        apply_now = pend_q & ((counting & wrap) | idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            div_q        <= DIV_WIDTH'(DEFAULT_DIV);
            phase_q      <= '0;
            pend_q       <= 1'b0;
            pend_div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            pend_phase_q <= '0;
            frozen_q     <= 1'b0;
            clk_out_q    <= 1'b0;
        end else begin
            if (cfg_we_direct) begin
                div_q   <= cfg_div;
                phase_q <= cfg_phase;
            end
            if (cfg_we_stage) begin
                pend_q       <= 1'b1;
                pend_div_q   <= cfg_div;
                pend_phase_q <= cfg_phase;
            end
            // Staged ratio takes over at the wrap, so the counter restarts from 0 with it.
            if (apply_now) begin
                div_q   <= pend_div_q;
                phase_q <= pend_phase_q;
                pend_q  <= 1'b0;
            end
            if (sync_load) begin
                cnt_q     <= (phase_q == '0) ? '0 : div_q - phase_q;
                clk_out_q <= 1'b0;
                frozen_q  <= 1'b0;
            end else if (counting) begin
                cnt_q <= wrap ? '0 : cnt_q + DIV_WIDTH'(1);
                // Freeze once low, never cutting a high phase or starting a new one.
                if (drain && (!clk_out_q || !hi)) begin
                    frozen_q  <= 1'b1;
                    clk_out_q <= 1'b0;
                end else begin
                    clk_out_q <= hi;
                end
            end else begin
                clk_out_q <= 1'b0;
            end
        end
    end

    assign clk_out = clk_out_q;
    assign frozen  = frozen_q;
    assign pending = pend_q;
    assign applied = apply_now;

endmodule

// File: rtl/pll_clk_out_divider.sv
// Multi-channel PLL post-divider: lock qualification, aligned start, staged reconfiguration.
module pll_clk_out_divider
    import pll_div_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned DIV_WIDTH   = 7,
    parameter int unsigned DEFAULT_DIV = 2,
    parameter int unsigned LOCK_DELAY  = 5,
    localparam int unsigned CHAN_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock_in,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [DIV_WIDTH-1:0] cfg_phase,
    output logic                 cfg_err,
    output logic [NUM_OUT-1:0]   clk_out,
    output logic                 lock_out,
    output logic                 aligned
);

    localparam int unsigned QW = $clog2(LOCK_DELAY + 1);

    if (!params_ok(NUM_OUT, DIV_WIDTH, DEFAULT_DIV, LOCK_DELAY)) begin : gen_param_check
        $error("pll_clk_out_divider: illegal parameter set");
    end

    pll_state_e         state_q;
    logic [QW-1:0]      qcnt_q;
    logic               lock_out_q, aligned_q, cfg_err_q;
    logic               accept, cfg_ok;
    logic [NUM_OUT-1:0] ch_we_direct, ch_we_stage, ch_frozen, ch_pending, ch_applied;

    always_comb begin
        cfg_ready    = (state_q != StSync) && (state_q != StDrain) && !(|ch_pending);
        accept       = cfg_valid & cfg_ready;
        cfg_ok       = (32'(cfg_chan) < NUM_OUT) && cfg_legal(32'(cfg_div), 32'(cfg_phase));
        ch_we_direct = '0;
        ch_we_stage  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (accept && cfg_ok && (cfg_chan == CHAN_W'(i))) begin
                ch_we_direct[i] = (state_q == StIdle) || (state_q == StQualify);
                ch_we_stage[i]  = (state_q == StRun);
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : gen_chan
        pll_div_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .sync_load    (state_q == StSync),
            .run          (state_q == StRun),
            .drain        (state_q == StDrain),
            .idle         (state_q == StIdle),
            .cfg_we_direct(ch_we_direct[g]),
            .cfg_we_stage (ch_we_stage[g]),
            .cfg_div      (cfg_div),
            .cfg_phase    (cfg_phase),
            .clk_out      (clk_out[g]),
            .frozen       (ch_frozen[g]),
            .pending      (ch_pending[g]),
            .applied      (ch_applied[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            qcnt_q     <= '0;
            lock_out_q <= 1'b0;
            aligned_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= accept & ~cfg_ok;
            case (state_q)
                StIdle: begin
                    if (pll_lock_in) begin
                        state_q <= StQualify;
                        qcnt_q  <= QW'(1);
                    end
                end
                StQualify: begin
                    if (!pll_lock_in) begin
                        state_q <= StIdle;
                    end else if (qcnt_q == QW'(LOCK_DELAY)) begin
                        state_q <= StSync;
                    end else begin
                        qcnt_q <= qcnt_q + QW'(1);
                    end
                end
                StSync: begin
                    state_q    <= StRun;
                    lock_out_q <= 1'b1;
                    aligned_q  <= 1'b1;
                end
                StRun: begin
                    if (!pll_lock_in) begin
                        state_q    <= StDrain;
                        lock_out_q <= 1'b0;
                        aligned_q  <= 1'b0;
                    end else if (|ch_applied) begin
                        aligned_q <= 1'b0;
                    end
                end
                StDrain: begin
                    // Lock is deliberately ignored here; a fresh qualification starts from idle.
                    if (&ch_frozen) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lock_out = lock_out_q;
    assign aligned  = aligned_q;
    assign cfg_err  = cfg_err_q;

endmodule
